// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: result source encoding and the
// buffered result entry layout.
package writeback_stage_pkg;

    localparam int WB_DATA_W     = 16;
    localparam int WB_ADDR_W     = 4;
    localparam int WB_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        WB_ALU0    = 2'd0,
        WB_ALU1    = 2'd1,
        WB_COMPLEX = 2'd2,
        WB_MEMORY  = 2'd3
    } wb_source_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Bus between issue/execution units and the writeback stage: fixed-path
// control, the two variable-latency handshakes and the register-file port.
interface writeback_stage_if #(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4
);
    logic                       WritebackEnIn;
    logic [1:0]                 WriteBackSourceIn;
    logic [REGADDRBITWIDTH-1:0] RegWriteAddrIn;
    logic [DATABITWIDTH-1:0]    ALU0_Result;
    logic [DATABITWIDTH-1:0]    ALU1_Result;
    logic                       ComplexValid;
    logic                       ComplexReady;
    logic [REGADDRBITWIDTH-1:0] ComplexAddr;
    logic [DATABITWIDTH-1:0]    ComplexData;
    logic                       MemValid;
    logic                       MemReady;
    logic [REGADDRBITWIDTH-1:0] MemAddr;
    logic [DATABITWIDTH-1:0]    MemData;
    logic                       RegFileWriteEn;
    logic [REGADDRBITWIDTH-1:0] RegFileWriteAddr;
    logic [DATABITWIDTH-1:0]    RegFileWriteData;
    logic                       WritebackCongestionStall;

    modport master (
        output WritebackEnIn, WriteBackSourceIn, RegWriteAddrIn,
        output ALU0_Result, ALU1_Result,
        output ComplexValid, ComplexAddr, ComplexData,
        output MemValid, MemAddr, MemData,
        input  ComplexReady, MemReady,
        input  RegFileWriteEn, RegFileWriteAddr, RegFileWriteData,
        input  WritebackCongestionStall
    );

    modport slave (
        input  WritebackEnIn, WriteBackSourceIn, RegWriteAddrIn,
        input  ALU0_Result, ALU1_Result,
        input  ComplexValid, ComplexAddr, ComplexData,
        input  MemValid, MemAddr, MemData,
        output ComplexReady, MemReady,
        output RegFileWriteEn, RegFileWriteAddr, RegFileWriteData,
        output WritebackCongestionStall
    );
endinterface

// File: rtl/writeback_result_fifo.sv
// Small power-of-two FIFO buffering one variable-latency result source.
// Callers gate push/pop with full/empty and the clock enable.
module writeback_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 20,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             i_srst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: owns the single register-file write port, shared by
// the 1-cycle ALU path and two buffered variable-latency result sources.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATABITWIDTH    = WB_DATA_W,
    parameter int REGADDRBITWIDTH = WB_ADDR_W,
    parameter int FIFODEPTH       = WB_FIFO_DEPTH
) (
    input logic              clk,
    input logic              clk_en,
    input logic              sync_rst,
    writeback_stage_if.slave bus
);

    localparam int ENTRYW = REGADDRBITWIDTH + DATABITWIDTH;
    localparam int CNTW   = $clog2(FIFODEPTH) + 1;

    wb_source_t                 w_src;
    logic                       r_fix_valid;
    wb_source_t                 r_fix_src;
    logic [REGADDRBITWIDTH-1:0] r_fix_addr;
    logic                       r_last_mem;

    logic [ENTRYW-1:0] w_cplx_head, w_mem_head;
    logic              w_cplx_full, w_cplx_empty, w_mem_full, w_mem_empty;
    logic [CNTW-1:0]   w_cplx_count, w_mem_count;
    logic              w_cplx_ready, w_mem_ready;
    logic              w_cplx_push, w_mem_push;
    logic              w_grant_cplx, w_grant_mem;

    logic                       w_we;
    logic [REGADDRBITWIDTH-1:0] w_waddr;
    logic [DATABITWIDTH-1:0]    w_wdata;

    assign w_src = wb_source_t'(bus.WriteBackSourceIn);

    // Readiness looks only at registered occupancy, so a same-cycle pop
    // never reopens a full FIFO.
    assign w_cplx_ready = clk_en && !w_cplx_full;
    assign w_mem_ready  = clk_en && !w_mem_full;
    assign w_cplx_push  = bus.ComplexValid && w_cplx_ready;
    assign w_mem_push   = bus.MemValid && w_mem_ready;

    // Issue-cycle control delayed one cycle to line up with the ALU results.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_fix_valid <= 1'b0;
            r_fix_src   <= WB_ALU0;
            r_fix_addr  <= '0;
        end else if (clk_en) begin
            r_fix_valid <= bus.WritebackEnIn && ((w_src == WB_ALU0) || (w_src == WB_ALU1));
            r_fix_src   <= w_src;
            r_fix_addr  <= bus.RegWriteAddrIn;
        end else begin
            r_fix_valid <= r_fix_valid;
            r_fix_src   <= r_fix_src;
            r_fix_addr  <= r_fix_addr;
        end
    end

    // Port arbitration: fixed path first, then round-robin between FIFOs.
    always_comb begin
        w_grant_cplx = 1'b0;
        w_grant_mem  = 1'b0;
        w_we         = 1'b0;
        w_waddr      = '0;
        w_wdata      = '0;
        if (!clk_en) begin
            w_we = 1'b0;
        end else if (r_fix_valid) begin
            w_we    = 1'b1;
            w_waddr = r_fix_addr;
            case (r_fix_src)
                WB_ALU1: w_wdata = bus.ALU1_Result;
                default: w_wdata = bus.ALU0_Result;
            endcase
        end else if (!w_cplx_empty && (w_mem_empty || r_last_mem)) begin
            w_grant_cplx = 1'b1;
            w_we         = 1'b1;
            w_waddr      = w_cplx_head[ENTRYW-1:DATABITWIDTH];
            w_wdata      = w_cplx_head[DATABITWIDTH-1:0];
        end else if (!w_mem_empty) begin
            w_grant_mem = 1'b1;
            w_we        = 1'b1;
            w_waddr     = w_mem_head[ENTRYW-1:DATABITWIDTH];
            w_wdata     = w_mem_head[DATABITWIDTH-1:0];
        end else begin
            w_we = 1'b0;
        end
    end

    // Last FIFO granted; starts at Memory so Complex wins the first tie.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_last_mem <= 1'b1;
        end else if (w_grant_cplx) begin
            r_last_mem <= 1'b0;
        end else if (w_grant_mem) begin
            r_last_mem <= 1'b1;
        end else begin
            r_last_mem <= r_last_mem;
        end
    end

    writeback_result_fifo #(.DEPTH(FIFODEPTH), .WIDTH(ENTRYW)) u_cplx_fifo (
        .clk     (clk),
        .i_srst  (sync_rst),
        .i_push  (w_cplx_push),
        .i_pop   (w_grant_cplx),
        .i_data  ({bus.ComplexAddr, bus.ComplexData}),
        .o_data  (w_cplx_head),
        .o_full  (w_cplx_full),
        .o_empty (w_cplx_empty),
        .o_count (w_cplx_count)
    );

    writeback_result_fifo #(.DEPTH(FIFODEPTH), .WIDTH(ENTRYW)) u_mem_fifo (
        .clk     (clk),
        .i_srst  (sync_rst),
        .i_push  (w_mem_push),
        .i_pop   (w_grant_mem),
        .i_data  ({bus.MemAddr, bus.MemData}),
        .o_data  (w_mem_head),
        .o_full  (w_mem_full),
        .o_empty (w_mem_empty),
        .o_count (w_mem_count)
    );

    assign bus.ComplexReady             = w_cplx_ready;
    assign bus.MemReady                 = w_mem_ready;
    assign bus.RegFileWriteEn           = w_we;
    assign bus.RegFileWriteAddr         = w_waddr;
    assign bus.RegFileWriteData         = w_wdata;
    assign bus.WritebackCongestionStall = (w_cplx_count == CNTW'(FIFODEPTH)) ||
                                          (w_mem_count == CNTW'(FIFODEPTH));

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the write port.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic clk_en;
    logic sync_rst;

    writeback_stage_if #(.DATABITWIDTH(16), .REGADDRBITWIDTH(4)) wb_if ();

    writeback_stage #(.DATABITWIDTH(16), .REGADDRBITWIDTH(4), .FIFODEPTH(DEPTH)) dut (
        .clk      (clk),
        .clk_en   (clk_en),
        .sync_rst (sync_rst),
        .bus      (wb_if)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatch = 0;

    // Reference model state
    wb_entry_t  q_cplx[$];
    wb_entry_t  q_mem[$];
    logic       m_pend;
    logic       m_pend_alu1;
    logic [3:0] m_pend_addr;
    logic       m_last_mem;

    // Values observed in the most recent step
    logic        obs_we, obs_cr, obs_mr, obs_stall;
    logic [3:0]  obs_addr;
    logic [15:0] obs_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_if.WritebackEnIn     = 1'b0;
        wb_if.WriteBackSourceIn = 2'd0;
        wb_if.RegWriteAddrIn    = 4'd0;
        wb_if.ALU0_Result       = 16'd0;
        wb_if.ALU1_Result       = 16'd0;
        wb_if.ComplexValid      = 1'b0;
        wb_if.ComplexAddr       = 4'd0;
        wb_if.ComplexData       = 16'd0;
        wb_if.MemValid          = 1'b0;
        wb_if.MemAddr           = 4'd0;
        wb_if.MemData           = 16'd0;
        clk_en                  = 1'b1;
        sync_rst                = 1'b0;
    endtask

    // One clock: compare outputs at the falling edge, advance model, cross the rising edge.
    task automatic step(input bit do_check);
        logic        e_we, e_cr, e_mr, e_stall, pop_c, pop_m;
        logic [3:0]  e_addr;
        logic [15:0] e_data;
        wb_entry_t   ent;
        @(negedge clk);
        e_cr    = clk_en && (q_cplx.size() < DEPTH);
        e_mr    = clk_en && (q_mem.size() < DEPTH);
        e_stall = (q_cplx.size() == DEPTH) || (q_mem.size() == DEPTH);
        e_we = 1'b0; e_addr = 4'd0; e_data = 16'd0; pop_c = 1'b0; pop_m = 1'b0;
        if (clk_en) begin
            if (m_pend) begin
                e_we = 1'b1; e_addr = m_pend_addr;
                e_data = m_pend_alu1 ? wb_if.ALU1_Result : wb_if.ALU0_Result;
            end else if (q_cplx.size() > 0 && (q_mem.size() == 0 || m_last_mem)) begin
                pop_c = 1'b1; e_we = 1'b1; e_addr = q_cplx[0].addr; e_data = q_cplx[0].data;
            end else if (q_mem.size() > 0) begin
                pop_m = 1'b1; e_we = 1'b1; e_addr = q_mem[0].addr; e_data = q_mem[0].data;
            end
        end
        obs_we = wb_if.RegFileWriteEn; obs_addr = wb_if.RegFileWriteAddr;
        obs_data = wb_if.RegFileWriteData; obs_cr = wb_if.ComplexReady;
        obs_mr = wb_if.MemReady; obs_stall = wb_if.WritebackCongestionStall;
        if (do_check) begin
            check_eq("we",    32'(obs_we),    32'(e_we));
            check_eq("waddr", 32'(obs_addr),  32'(e_addr));
            check_eq("wdata", 32'(obs_data),  32'(e_data));
            check_eq("cready", 32'(obs_cr),   32'(e_cr));
            check_eq("mready", 32'(obs_mr),   32'(e_mr));
            check_eq("stall", 32'(obs_stall), 32'(e_stall));
        end
        if (sync_rst) begin
            q_cplx.delete(); q_mem.delete();
            m_pend = 1'b0; m_last_mem = 1'b1;
        end else if (clk_en) begin
            if (pop_c) begin void'(q_cplx.pop_front()); m_last_mem = 1'b0; end
            if (pop_m) begin void'(q_mem.pop_front()); m_last_mem = 1'b1; end
            if (wb_if.ComplexValid && e_cr) begin
                ent.addr = wb_if.ComplexAddr; ent.data = wb_if.ComplexData; q_cplx.push_back(ent);
            end
            if (wb_if.MemValid && e_mr) begin
                ent.addr = wb_if.MemAddr; ent.data = wb_if.MemData; q_mem.push_back(ent);
            end
            m_pend      = wb_if.WritebackEnIn && (wb_if.WriteBackSourceIn < 2'd2);
            m_pend_alu1 = (wb_if.WriteBackSourceIn == 2'd1);
            m_pend_addr = wb_if.RegWriteAddrIn;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_pend = 1'b0; m_pend_alu1 = 1'b0; m_pend_addr = 4'd0; m_last_mem = 1'b1;
        idle_inputs();
        sync_rst = 1'b1;
        #1;
        step(1'b0);
        idle_inputs();

        // Idle after reset
        step(1'b1);
        check_eq("rst_we", 32'(obs_we), 32'd0);
        check_eq("rst_rdy", 32'({obs_cr, obs_mr, obs_stall}), 32'b110);

        // ALU1 write exactly one cycle after issue
        wb_if.WritebackEnIn = 1'b1; wb_if.WriteBackSourceIn = 2'd1; wb_if.RegWriteAddrIn = 4'd5;
        step(1'b1);
        idle_inputs(); wb_if.ALU1_Result = 16'h1234;
        step(1'b1);
        check_eq("alu1_wr", 32'({obs_we, obs_addr, obs_data}), 32'({1'b1, 4'd5, 16'h1234}));

        // Simultaneous Complex and Mem: Complex first, then Mem
        idle_inputs();
        wb_if.ComplexValid = 1'b1; wb_if.ComplexAddr = 4'd3; wb_if.ComplexData = 16'hAAAA;
        wb_if.MemValid = 1'b1; wb_if.MemAddr = 4'd7; wb_if.MemData = 16'h5555;
        step(1'b1);
        idle_inputs();
        step(1'b1);
        check_eq("rr_first", 32'({obs_we, obs_addr, obs_data}), 32'({1'b1, 4'd3, 16'hAAAA}));
        step(1'b1);
        check_eq("rr_second", 32'({obs_we, obs_addr, obs_data}), 32'({1'b1, 4'd7, 16'h5555}));

        // Fixed stream fills Mem FIFO and raises stall
        idle_inputs();
        wb_if.WritebackEnIn = 1'b1; wb_if.RegWriteAddrIn = 4'd1;
        wb_if.MemValid = 1'b1; wb_if.MemAddr = 4'd9; wb_if.MemData = 16'h1111;
        step(1'b1);
        wb_if.WriteBackSourceIn = 2'd1; wb_if.RegWriteAddrIn = 4'd2;
        wb_if.ALU0_Result = 16'h0101; wb_if.MemAddr = 4'd10; wb_if.MemData = 16'h2222;
        step(1'b1);
        wb_if.WriteBackSourceIn = 2'd0; wb_if.RegWriteAddrIn = 4'd3;
        wb_if.ALU1_Result = 16'h0202; wb_if.MemValid = 1'b0;
        step(1'b1);
        check_eq("full_stall", 32'({obs_mr, obs_stall}), 32'b01);
        idle_inputs(); wb_if.ALU0_Result = 16'h0303;
        step(1'b1);
        step(1'b1);
        check_eq("mem_pop1", 32'({obs_we, obs_addr, obs_data}), 32'({1'b1, 4'd9, 16'h1111}));
        step(1'b1);
        check_eq("mem_pop2", 32'({obs_we, obs_addr, obs_data, obs_stall}), 32'({1'b1, 4'd10, 16'h2222, 1'b0}));

        // Source 2 issue leaves the port to a pending Complex entry
        idle_inputs();
        wb_if.WritebackEnIn = 1'b1; wb_if.RegWriteAddrIn = 4'd4;
        wb_if.ComplexValid = 1'b1; wb_if.ComplexAddr = 4'd6; wb_if.ComplexData = 16'hBEEF;
        step(1'b1);
        idle_inputs();
        wb_if.WritebackEnIn = 1'b1; wb_if.WriteBackSourceIn = 2'd2; wb_if.RegWriteAddrIn = 4'd8;
        wb_if.ALU0_Result = 16'h4444;
        step(1'b1);
        idle_inputs();
        step(1'b1);
        check_eq("src2_cplx", 32'({obs_we, obs_addr, obs_data}), 32'({1'b1, 4'd6, 16'hBEEF}));

        // clk_en low with data buffered, then reset mid-stream
        wb_if.WritebackEnIn = 1'b1;
        wb_if.ComplexValid = 1'b1; wb_if.ComplexAddr = 4'd11; wb_if.ComplexData = 16'hC0DE;
        wb_if.MemValid = 1'b1; wb_if.MemAddr = 4'd12; wb_if.MemData = 16'hD00D;
        step(1'b1);
        idle_inputs(); clk_en = 1'b0; wb_if.ComplexValid = 1'b1; wb_if.MemValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check_eq("hold", 32'({obs_we, obs_cr, obs_mr}), 32'd0);
        end
        idle_inputs(); sync_rst = 1'b1;
        step(1'b1);
        idle_inputs();
        step(1'b1);
        check_eq("post_rst", 32'({obs_we, obs_cr, obs_mr, obs_stall}), 32'b0110);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            wb_if.WritebackEnIn     = ($urandom_range(0, 99) < 55);
            wb_if.WriteBackSourceIn = 2'($urandom_range(0, 3));
            wb_if.RegWriteAddrIn    = 4'($urandom);
            wb_if.ALU0_Result       = 16'($urandom);
            wb_if.ALU1_Result       = 16'($urandom);
            wb_if.ComplexValid      = ($urandom_range(0, 99) < 40);
            wb_if.ComplexAddr       = 4'($urandom);
            wb_if.ComplexData       = 16'($urandom);
            wb_if.MemValid          = ($urandom_range(0, 99) < 40);
            wb_if.MemAddr           = 4'($urandom);
            wb_if.MemData           = 16'($urandom);
            clk_en                  = ($urandom_range(0, 99) < 90);
            sync_rst                = ($urandom_range(0, 299) == 0);
            step(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
